// File: rtl/ram_bist_if.sv
// Control/status bundle for ram_bist: the master starts a test and reads back the result,
// the slave is the BIST engine.
interface ram_bist_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              inj_en;
  logic [ADDR_W-1:0] inj_addr;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic              err_phase;

  modport master (
    output start, inj_en, inj_addr,
    input  busy, done, pass, err_count, first_err_addr, err_phase
  );

  modport slave (
    input  start, inj_en, inj_addr,
    output busy, done, pass, err_count, first_err_addr, err_phase
  );
endinterface

// File: rtl/ram_bist.sv
// Two-phase march BIST over an inferred single-port block RAM: write P(a), read/compare,
// write ~P(a), read/compare; reports pass, saturating error count and first failure.
module ram_bist #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter logic [31:0] SEED   = 32'h0E,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       hw_clk,
  input  logic       rst_n,
  ram_bist_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {StIdle, StWr0, StRd0, StWr1, StRd1, StDone} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_drain;
  logic              r_inj_en;
  logic [ADDR_W-1:0] r_inj_addr;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic              r_cmp_phase;
  logic [DATA_W-1:0] r_cmp_exp;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [CNT_W-1:0]  r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              r_err_phase;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] w_pat;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_wdata;
  logic              w_phase;
  logic              w_inj;
  logic              w_we;
  logic              w_re;
  logic              w_mismatch;
  logic [CNT_W-1:0]  w_err_next;

  always_comb begin
    w_pat      = DATA_W'(32'(r_addr) + SEED);
    w_phase    = (r_state == StWr1) || (r_state == StRd1);
    w_word     = w_phase ? ~w_pat : w_pat;
    w_inj      = r_inj_en && (r_addr == r_inj_addr);
    w_wdata    = w_word ^ DATA_W'(w_inj);
    w_we       = (r_state == StWr0) || (r_state == StWr1);
    w_re       = ((r_state == StRd0) || (r_state == StRd1)) && !r_drain;
    w_mismatch = r_cmp_valid && (r_rdata != r_cmp_exp);
    w_err_next = (w_mismatch && (r_err_count != CNT_MAX)) ? r_err_count + 1'b1 : r_err_count;
  end

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge hw_clk) begin
    if (w_we) begin
      r_mem[r_addr] <= w_wdata;
    end
    r_rdata <= r_mem[r_addr];
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= StIdle;
      r_addr           <= '0;
      r_drain          <= 1'b0;
      r_inj_en         <= 1'b0;
      r_inj_addr       <= '0;
      r_cmp_valid      <= 1'b0;
      r_cmp_addr       <= '0;
      r_cmp_phase      <= 1'b0;
      r_cmp_exp        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
      r_err_phase      <= 1'b0;
    end else begin
      // Compare pipeline: address and expected word travel with the RAM read.
      r_cmp_valid <= w_re;
      r_cmp_addr  <= r_addr;
      r_cmp_exp   <= w_word;
      r_cmp_phase <= w_phase;
      if (w_mismatch) begin
        if (r_err_count == '0) begin
          r_first_err_addr <= r_cmp_addr;
          r_err_phase      <= r_cmp_phase;
        end
        r_err_count <= w_err_next;
      end

      unique case (r_state)
        StIdle, StDone: begin
          if (bus.start) begin
            r_state          <= StWr0;
            r_addr           <= '0;
            r_drain          <= 1'b0;
            r_inj_en         <= bus.inj_en;
            r_inj_addr       <= bus.inj_addr;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_err_phase      <= 1'b0;
          end
        end
        StWr0, StWr1: begin
          r_addr <= r_addr + 1'b1;
          if (r_addr == LAST_ADDR) begin
            r_state <= (r_state == StWr0) ? StRd0 : StRd1;
          end
        end
        StRd0, StRd1: begin
          if (r_drain) begin
            r_drain <= 1'b0;
            if (r_state == StRd0) begin
              r_state <= StWr1;
            end else begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end else begin
            r_addr <= r_addr + 1'b1;
            if (r_addr == LAST_ADDR) begin
              r_drain <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err_count;
  assign bus.first_err_addr = r_first_err_addr;
  assign bus.err_phase      = r_err_phase;
endmodule

// File: tb/tb_ram_bist.sv
// Randomized bench for ram_bist: three parameterisations checked against an array-based
// march model.
module tb_ram_bist;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_W(8), .CNT_W(16)) bus_d ();
  ram_bist_if #(.ADDR_W(4), .CNT_W(16)) bus_s ();
  ram_bist_if #(.ADDR_W(8), .CNT_W(1))  bus_c ();

  ram_bist dut_d (.hw_clk(clk), .rst_n(rst_n), .bus(bus_d.slave));
  ram_bist #(.DATA_W(16), .ADDR_W(4), .SEED(32'h1234), .CNT_W(16)) dut_s (
    .hw_clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
  );
  ram_bist #(.CNT_W(1)) dut_c (.hw_clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  int n_cmp  = 0;
  int n_fail = 0;
  bit seen_a5 = 1'b0;

  int cfg_depth [3] = '{256, 16, 256};
  int cfg_dw    [3] = '{8, 16, 8};
  int cfg_seed  [3] = '{'h0E, 'h1234, 'h0E};
  int cfg_cw    [3] = '{16, 16, 1};

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // field: 0 busy, 1 done, 2 pass, 3 err_count, 4 first_err_addr, 5 err_phase
  function automatic longint st(input int sel, input int field);
    longint v;
    v = 0;
    case (sel)
      0: case (field)
        0: v = bus_d.busy;      1: v = bus_d.done;           2: v = bus_d.pass;
        3: v = bus_d.err_count; 4: v = bus_d.first_err_addr; default: v = bus_d.err_phase;
      endcase
      1: case (field)
        0: v = bus_s.busy;      1: v = bus_s.done;           2: v = bus_s.pass;
        3: v = bus_s.err_count; 4: v = bus_s.first_err_addr; default: v = bus_s.err_phase;
      endcase
      default: case (field)
        0: v = bus_c.busy;      1: v = bus_c.done;           2: v = bus_c.pass;
        3: v = bus_c.err_count; 4: v = bus_c.first_err_addr; default: v = bus_c.err_phase;
      endcase
    endcase
    return v;
  endfunction

  task automatic drive_start(input int sel, input logic s);
    case (sel)
      0:       bus_d.start = s;
      1:       bus_s.start = s;
      default: bus_c.start = s;
    endcase
  endtask

  task automatic drive_inj(input int sel, input logic ie, input int ia);
    case (sel)
      0:       begin bus_d.inj_en = ie; bus_d.inj_addr = ia[7:0]; end
      1:       begin bus_s.inj_en = ie; bus_s.inj_addr = ia[3:0]; end
      default: begin bus_c.inj_en = ie; bus_c.inj_addr = ia[7:0]; end
    endcase
  endtask

  // Full march on a plain array, counting every mismatch the two read passes would see.
  function automatic void model(input int sel, input bit ie, input int ia, output longint cnt,
                                output longint first, output longint ph, output longint pass);
    longint mem [256];
    longint mask, w, cmax;
    int     errs;
    mask  = (64'd1 << cfg_dw[sel]) - 1;
    cmax  = (64'd1 << cfg_cw[sel]) - 1;
    errs  = 0;
    first = 0;
    ph    = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < cfg_depth[sel]; a++) begin
        w = (a + cfg_seed[sel]) & mask;
        if (p == 1) w = ~w & mask;
        if (ie && a == ia) w = w ^ 1;
        mem[a] = w;
      end
      for (int a = 0; a < cfg_depth[sel]; a++) begin
        w = (a + cfg_seed[sel]) & mask;
        if (p == 1) w = ~w & mask;
        if (mem[a] != w) begin
          if (errs == 0) begin
            first = a;
            ph    = p;
          end
          errs++;
        end
      end
    end
    cnt  = (errs > cmax) ? cmax : longint'(errs);
    pass = (errs == 0);
  endfunction

  // Called at a negedge; j1/j2 are busy-cycle indices at which a stray start is pulsed.
  task automatic run(input int sel, input bit ie, input int ia, input int j1, input int j2);
    longint e_cnt, e_first, e_ph, e_pass;
    int     cnt;
    drive_inj(sel, ie, ia);
    drive_start(sel, 1'b1);
    @(negedge clk);
    drive_start(sel, 1'b0);
    check("start_busy", st(sel, 0), 1);
    check("start_done_clr", st(sel, 1), 0);
    check("start_cnt_clr", st(sel, 3), 0);
    cnt = 0;
    while (st(sel, 0) == 1 && cnt < 5000) begin
      cnt++;
      if (cnt == j1 || cnt == j2) begin
        drive_start(sel, 1'b1);
        drive_inj(sel, 1'($urandom), int'($urandom_range(0, cfg_depth[sel] - 1)));
      end else begin
        drive_start(sel, 1'b0);
      end
      @(negedge clk);
    end
    drive_start(sel, 1'b0);
    model(sel, ie, ia, e_cnt, e_first, e_ph, e_pass);
    check("busy_cycles", cnt, 4 * cfg_depth[sel] + 2);
    check("done", st(sel, 1), 1);
    check("pass", st(sel, 2), e_pass);
    check("err_count", st(sel, 3), e_cnt);
    check("first_err_addr", st(sel, 4), e_first);
    check("err_phase", st(sel, 5), e_ph);
  endtask

  always @(negedge clk) begin
    if (dut_s.r_cmp_valid && dut_s.r_cmp_addr == 4'd5 && !dut_s.r_cmp_phase && !seen_a5) begin
      seen_a5 = 1'b1;
      check("rd0_a5_data", longint'(dut_s.r_rdata), 'h1239);
    end
  end

  initial begin
    int cnt;
    for (int s = 0; s < 3; s++) begin
      drive_start(s, 1'b0);
      drive_inj(s, 1'b0, 0);
    end
    #2;
    for (int f = 0; f < 6; f++) check("reset_val", st(0, f), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 1'b0, 0, 10, 500);
    run(0, 1'b1, 3, 0, 4 * 256 + 2);
    @(negedge clk);
    check("final_start_ignored", st(0, 0), 0);
    check("done_sticky", st(0, 1), 1);
    @(negedge clk);
    run(0, 1'b0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      run(0, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(1, 1026)), 0);
    end

    // Asynchronous reset while RD0 is at address 100.
    drive_inj(0, 1'b1, 7);
    drive_start(0, 1'b1);
    @(negedge clk);
    drive_start(0, 1'b0);
    cnt = 1;
    while (cnt < 357) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_before_rst", st(0, 0), 1);
    #1 rst_n = 1'b0;
    #1;
    for (int f = 0; f < 6; f++) check("async_rst_val", st(0, f), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 0, 0, 0);

    run(1, 1'b0, 0, 0, 0);
    check("seen_a5", seen_a5, 1);
    run(1, 1'b1, int'($urandom_range(0, 15)), 0, 0);

    run(2, 1'b1, 0, 0, 0);
    run(2, 1'b1, int'($urandom_range(0, 255)), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
